// File: rtl/mul_div_unit.sv
// ============================================================================
// Module   : mul_div_unit
// Summary  : E-stage multiply/divide unit with fixed-latency HI/LO commit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic        req,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [0:0] c_IDLE     = 1'b0;
  localparam logic [0:0] c_RUN      = 1'b1;
  localparam logic [3:0] c_MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] c_DIV_CNT  = 4'(DIV_CYCLES);

  logic [0:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        dz_q, dz_d;

  logic        w_is_md, w_is_div, w_sdiv, w_launch;
  logic [63:0] w_a_ext, w_b_ext, w_prod;
  logic [31:0] w_a_mag, w_b_mag, w_b_safe, w_q_mag, w_r_mag, w_quo, w_rem;

  assign w_is_md  = (md_op >= 3'd1) && (md_op <= 3'd4);
  assign w_is_div = (md_op == 3'd3) || (md_op == 3'd4);
  assign w_sdiv   = (md_op == 3'd3);
  assign w_launch = (state_q == c_IDLE) && start && !req && w_is_md;

  // Low 64 bits of the extended product are correct for both signed and unsigned.
  assign w_a_ext = (md_op == 3'd1) ? {{32{A[31]}}, A} : {32'b0, A};
  assign w_b_ext = (md_op == 3'd1) ? {{32{B[31]}}, B} : {32'b0, B};
  assign w_prod  = w_a_ext * w_b_ext;

  // Sign-magnitude division sidesteps the 0x80000000 / -1 overflow case.
  assign w_a_mag  = (w_sdiv && A[31]) ? (32'd0 - A) : A;
  assign w_b_mag  = (w_sdiv && B[31]) ? (32'd0 - B) : B;
  assign w_b_safe = (B == 32'd0) ? 32'd1 : w_b_mag;
  assign w_q_mag  = w_a_mag / w_b_safe;
  assign w_r_mag  = w_a_mag % w_b_safe;
  assign w_quo    = (w_sdiv && (A[31] ^ B[31])) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_rem    = (w_sdiv && A[31]) ? (32'd0 - w_r_mag) : w_r_mag;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= c_IDLE;
      cnt_q    <= 4'd0;
      hi_tmp_q <= 32'd0;
      lo_tmp_q <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_tmp_q <= hi_tmp_d;
      lo_tmp_q <= lo_tmp_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dz_q     <= dz_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_tmp_d = hi_tmp_q;
    lo_tmp_d = lo_tmp_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = dz_q;
    case (state_q)
      c_IDLE: begin
        if (w_launch) begin
          state_d  = c_RUN;
          cnt_d    = w_is_div ? c_DIV_CNT : c_MULT_CNT;
          hi_tmp_d = w_is_div ? w_rem : w_prod[63:32];
          lo_tmp_d = w_is_div ? w_quo : w_prod[31:0];
          dz_d     = w_is_div && (B == 32'd0);
        end else if (!req && (md_op == 3'd5)) begin
          hi_d = A;
        end else if (!req && (md_op == 3'd6)) begin
          lo_d = A;
        end
      end
      c_RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = c_IDLE;
          if (!dz_q) begin
            hi_d = hi_tmp_q;
            lo_d = lo_tmp_q;
          end
        end
      end
      default: state_d = c_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == c_RUN);
  end

  assign HI = hi_q;
  assign LO = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================================
// Module   : tb_mul_div_unit
// Summary  : Vector table plus scoreboard bench for mul_div_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset, start, req, busy;
  logic [2:0]  md_op;
  logic [31:0] A, B, HI, LO;

  int checks   = 0;
  int failures = 0;

  logic [63:0] sb_q[$];
  logic [31:0] m_hi, m_lo;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    int          n;
    string       name;
  } vec_t;

  vec_t vecs[9];

  mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .req(req),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one launch, then measure busy length and compare the committed HI/LO.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int n, input string name);
    int cycles;
    logic [63:0] e;
    A = a; B = b; md_op = op; start = 1'b1; req = 1'b0;
    sb_q.push_back(exp);
    tick();
    start = 1'b0; md_op = 3'd0;
    cycles = 0;
    while (busy === 1'b1 && cycles < 40) begin
      cycles++;
      tick();
    end
    check({name, " latency"}, 64'(cycles), 64'(n));
    e = sb_q.pop_front();
    check({name, " result"}, {HI, LO}, e);
    m_hi = e[63:32];
    m_lo = e[31:0];
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] val, input logic rq);
    md_op = op; A = val; req = rq;
    tick();
    md_op = 3'd0; req = 1'b0;
  endtask

  initial begin
    int cycles;
    logic [63:0] e;

    vecs[0] = '{3'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5,  "mult -2*3"};
    vecs[1] = '{3'd2, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5,  "multu"};
    vecs[2] = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10, "div -7/2"};
    vecs[3] = '{3'd4, 32'd7,        32'd2,        32'h00000001, 32'h00000003, 10, "divu 7/2"};
    vecs[4] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10, "div ovf"};
    vecs[5] = '{3'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10, "div 7/-2"};
    vecs[6] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5,  "mult min*min"};
    vecs[7] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5,  "multu max*max"};
    vecs[8] = '{3'd4, 32'hFFFFFFFF, 32'd10,       32'h00000005, 32'h19999999, 10, "divu max/10"};

    reset = 1'b1; start = 1'b0; req = 1'b0; md_op = 3'd0; A = '0; B = '0;
    m_hi = '0; m_lo = '0;
    tick(); tick();
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      check("idle busy", 64'(busy), 64'd0);
      check("idle HI/LO", {HI, LO}, 64'd0);
      tick();
    end

    for (int i = 0; i < 9; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo}, vecs[i].n, vecs[i].name);

    // MTHI / MTLO, then divide by zero must leave them in place.
    mt(3'd5, 32'h11, 1'b0);
    check("mthi", {HI, LO}, {32'h11, m_lo});
    mt(3'd6, 32'h22, 1'b0);
    check("mtlo", {HI, LO}, 64'h00000011_00000022);
    m_hi = 32'h11; m_lo = 32'h22;
    run_op(3'd4, 32'd7, 32'd0, {m_hi, m_lo}, 10, "divu by zero");

    // req blocks launch and MTLO.
    A = 32'd3; B = 32'd3; md_op = 3'd1; start = 1'b1; req = 1'b1;
    tick();
    start = 1'b0; md_op = 3'd0; req = 1'b0;
    check("req blocks launch", 64'(busy), 64'd0);
    mt(3'd6, 32'h99, 1'b1);
    for (int i = 0; i < 6; i++) tick();
    check("req blocks HI/LO", {HI, LO}, {m_hi, m_lo});

    // start with non-MDU op codes is ignored.
    A = 32'd5; B = 32'd5; md_op = 3'd7; start = 1'b1;
    tick();
    md_op = 3'd0;
    tick();
    start = 1'b0;
    check("start bad op", {31'd0, busy, HI, LO}, {32'd0, m_hi, m_lo});

    // MTLO and a second start during RUN are ignored; MULT commits.
    A = 32'd4; B = 32'd5; md_op = 3'd1; start = 1'b1;
    sb_q.push_back(64'd20);
    tick();
    start = 1'b0;
    check("run busy", 64'(busy), 64'd1);
    md_op = 3'd6; A = 32'hDEAD;
    tick();
    md_op = 3'd3; start = 1'b1; A = 32'd100; B = 32'd7;
    tick();
    start = 1'b0; md_op = 3'd0;
    cycles = 2;
    while (busy === 1'b1 && cycles < 40) begin
      cycles++;
      tick();
    end
    check("run ignore latency", 64'(cycles), 64'd5);
    e = sb_q.pop_front();
    check("run ignore result", {HI, LO}, e);
    m_hi = e[63:32]; m_lo = e[31:0];

    // Reset at T0+3 of a DIV aborts it.
    A = 32'd100; B = 32'd7; md_op = 3'd3; start = 1'b1;
    tick();
    start = 1'b0; md_op = 3'd0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    check("reset busy", 64'(busy), 64'd0);
    check("reset HI/LO", {HI, LO}, 64'd0);
    for (int i = 0; i < 12; i++) tick();
    check("no commit after reset", {31'd0, busy, HI, LO}, {32'd0, m_hi, m_lo});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
